// File: rtl/bch_decoder.sv
// rtl/bch_decoder.sv - bit-serial BCH(63,51) t=2 decoder with inversion-free Chien-search correction
module bch_decoder #(
    parameter int N = 63,
    parameter int K = 51
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic         data_in,
    input  logic         ready_in,
    output logic         valid_out,
    output logic         data_out,
    output logic [K-1:0] data_out_all,
    output logic [1:0]   err_count,
    output logic         uncorrectable,
    output logic         done
);

    localparam logic [5:0] LAST     = 6'(N - 1);
    localparam logic [5:0] MSG_LAST = 6'(K - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        SIGMA = 3'd2,
        CHIEN = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [5:0]   cnt;
    logic [N-1:0] cw;
    logic [N-1:0] raw;
    logic [5:0]   s1, s3;
    logic [5:0]   c0, t1, t2;
    logic [1:0]   roots, exp_roots, err_int;
    logic         corr_en, unc_int;

    // Multiply by alpha in GF(64), p(x) = x^6 + x + 1: alpha^6 folds back to alpha + 1.
    function automatic logic [5:0] mul_a(input logic [5:0] x);
        return {x[4:0], 1'b0} ^ {4'b0000, x[5], x[5]};
    endfunction

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] acc;
        logic [5:0] sh;
        acc = 6'd0;
        sh  = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = mul_a(sh);
        end
        return acc;
    endfunction

    logic [5:0] s1_sq, s1_cu, d_term, chien_sum;
    logic [1:0] roots_nxt;
    logic       accept, flip;

    assign s1_sq     = gf_mul(s1, s1);
    assign s1_cu     = gf_mul(s1_sq, s1);
    assign d_term    = s3 ^ s1_cu;
    assign chien_sum = c0 ^ t1 ^ t2;
    assign flip      = (state == CHIEN) && corr_en && (chien_sum == 6'd0);
    assign roots_nxt = roots + {1'b0, flip};
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready_out = 1'b0;
        valid_out = 1'b0;
        data_out  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) state_nxt = RECV;
            end
            RECV: begin
                ready_out = 1'b1;
                if (valid_in && cnt == LAST) state_nxt = SIGMA;
            end
            SIGMA: state_nxt = CHIEN;
            CHIEN: begin
                if (cnt == LAST) state_nxt = OUT;
            end
            OUT: begin
                valid_out = 1'b1;
                data_out  = cw[LAST - cnt];
                if (ready_in && cnt == MSG_LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 6'd0;
            cw            <= '0;
            raw           <= '0;
            s1            <= 6'd0;
            s3            <= 6'd0;
            c0            <= 6'd0;
            t1            <= 6'd0;
            t2            <= 6'd0;
            roots         <= 2'd0;
            exp_roots     <= 2'd0;
            err_int       <= 2'd0;
            corr_en       <= 1'b0;
            unc_int       <= 1'b0;
            data_out_all  <= '0;
            err_count     <= 2'd0;
            uncorrectable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cw[LAST]  <= data_in;
                        raw[LAST] <= data_in;
                        s1        <= {5'd0, data_in};
                        s3        <= {5'd0, data_in};
                        cnt       <= 6'd1;
                    end
                end
                RECV: begin
                    if (accept) begin
                        cw[LAST - cnt]  <= data_in;
                        raw[LAST - cnt] <= data_in;
                        s1  <= mul_a(s1) ^ {5'd0, data_in};
                        s3  <= mul_a(mul_a(mul_a(s3))) ^ {5'd0, data_in};
                        cnt <= (cnt == LAST) ? 6'd0 : cnt + 6'd1;
                    end
                end
                SIGMA: begin
                    // Locator scaled by S1 so no field inversion is needed; roots are unchanged.
                    c0        <= s1;
                    t1        <= mul_a(s1_sq);
                    t2        <= mul_a(mul_a(d_term));
                    corr_en   <= (s1 != 6'd0);
                    unc_int   <= (s1 == 6'd0) && (s3 != 6'd0);
                    exp_roots <= (s1 == 6'd0) ? 2'd0 : ((d_term == 6'd0) ? 2'd1 : 2'd2);
                    roots     <= 2'd0;
                    cnt       <= 6'd0;
                end
                CHIEN: begin
                    if (flip) cw[LAST - cnt] <= ~cw[LAST - cnt];
                    roots <= roots_nxt;
                    t1    <= mul_a(t1);
                    t2    <= mul_a(mul_a(t2));
                    if (cnt == LAST) begin
                        cnt <= 6'd0;
                        // A root-count shortfall means more than two errors; hand on the word as received.
                        if (roots_nxt != exp_roots) begin
                            unc_int <= 1'b1;
                            cw      <= raw;
                            err_int <= 2'd0;
                        end else begin
                            err_int <= roots_nxt;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                OUT: begin
                    if (ready_in) begin
                        if (cnt == MSG_LAST) begin
                            cnt           <= 6'd0;
                            data_out_all  <= cw[N-1:N-K];
                            err_count     <= err_int;
                            uncorrectable <= unc_int;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    cnt       <= 6'd0;
                    s1        <= 6'd0;
                    s3        <= 6'd0;
                    c0        <= 6'd0;
                    t1        <= 6'd0;
                    t2        <= 6'd0;
                    roots     <= 2'd0;
                    exp_roots <= 2'd0;
                    err_int   <= 2'd0;
                    corr_en   <= 1'b0;
                    unc_int   <= 1'b0;
                end
                default: cnt <= 6'd0;
            endcase
        end
    end

endmodule
